// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage. Credit-limited word requests,
// in-order response buffer, IF/ID register, stall and redirect squash.
package fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] fetched_inst;
  } if_id_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output if_id_t      if_id_reg,
  output logic        if_id_valid
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
  localparam if_id_t        BUBBLE   = '{pc: 32'h0000_0000, fetched_inst: NOP_INST};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == LAST_IDX) ? '0 : p + PW'(1'b1);
  endfunction

  logic [31:0]   fetch_pc_r, fetch_pc_nxt;
  logic [CW-1:0] out_cnt_r, out_cnt_nxt;
  logic [CW-1:0] drop_cnt_r, drop_cnt_nxt;
  logic [CW-1:0] fifo_cnt_r, fifo_cnt_nxt;
  logic [PW-1:0] fifo_rd_r, fifo_rd_nxt, fifo_wr_r, fifo_wr_nxt;
  logic [PW-1:0] pcq_rd_r, pcq_wr_r;
  logic [31:0]   fifo_pc_r   [FIFO_DEPTH];
  logic [31:0]   fifo_inst_r [FIFO_DEPTH];
  logic [31:0]   pcq_pc_r    [FIFO_DEPTH];
  if_id_t        if_id_r, if_id_nxt;
  logic          if_id_valid_r, if_id_valid_nxt;

  logic          credit_s, req_valid_s, fire_s, rsp_keep_s;
  logic          fifo_push_s, fifo_pop_s;
  logic [31:0]   rsp_pc_s;

  // Credits count both in-flight requests and buffered responses, so the FIFO can never overflow
  assign credit_s    = ({1'b0, out_cnt_r} + {1'b0, fifo_cnt_r}) < DEPTH_C;
  assign req_valid_s = !reset && !redirect_valid && credit_s;
  assign fire_s      = req_valid_s && imem_req_ready;
  assign rsp_pc_s    = pcq_pc_r[pcq_rd_r];
  assign rsp_keep_s  = imem_rsp_valid && (drop_cnt_r == '0) && !redirect_valid;

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;
  assign if_id_reg      = if_id_r;
  assign if_id_valid    = if_id_valid_r;

  // Next-state for fetch PC, counters, FIFO pointers and the IF/ID register
  always_comb begin
    fetch_pc_nxt    = fetch_pc_r;
    drop_cnt_nxt    = drop_cnt_r;
    fifo_cnt_nxt    = fifo_cnt_r;
    fifo_rd_nxt     = fifo_rd_r;
    fifo_wr_nxt     = fifo_wr_r;
    if_id_nxt       = if_id_r;
    if_id_valid_nxt = if_id_valid_r;
    fifo_push_s     = 1'b0;
    fifo_pop_s      = 1'b0;
    out_cnt_nxt     = out_cnt_r + CW'(fire_s) - CW'(imem_rsp_valid);

    if (redirect_valid) begin
      // Every still-outstanding response belongs to the wrong path
      fetch_pc_nxt    = redirect_pc & 32'hFFFF_FFFC;
      drop_cnt_nxt    = out_cnt_r - CW'(imem_rsp_valid);
      fifo_cnt_nxt    = '0;
      fifo_rd_nxt     = '0;
      fifo_wr_nxt     = '0;
      if_id_nxt       = BUBBLE;
      if_id_valid_nxt = 1'b0;
    end else begin
      if (fire_s) begin
        fetch_pc_nxt = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_nxt = fetch_pc_r;
      end

      if (imem_rsp_valid && (drop_cnt_r != '0)) begin
        drop_cnt_nxt = drop_cnt_r - CW'(1'b1);
      end else begin
        drop_cnt_nxt = drop_cnt_r;
      end

      if (stall) begin
        if_id_nxt       = if_id_r;
        if_id_valid_nxt = if_id_valid_r;
        fifo_push_s     = rsp_keep_s;
      end else if (fifo_cnt_r != '0) begin
        fifo_pop_s      = 1'b1;
        fifo_push_s     = rsp_keep_s;
        if_id_nxt       = '{pc: fifo_pc_r[fifo_rd_r], fetched_inst: fifo_inst_r[fifo_rd_r]};
        if_id_valid_nxt = 1'b1;
      end else if (rsp_keep_s) begin
        if_id_nxt       = '{pc: rsp_pc_s, fetched_inst: imem_rsp_data};
        if_id_valid_nxt = 1'b1;
      end else begin
        if_id_nxt       = BUBBLE;
        if_id_valid_nxt = 1'b0;
      end

      fifo_cnt_nxt = fifo_cnt_r + CW'(fifo_push_s) - CW'(fifo_pop_s);
      if (fifo_push_s) begin
        fifo_wr_nxt = ptr_inc(fifo_wr_r);
      end else begin
        fifo_wr_nxt = fifo_wr_r;
      end
      if (fifo_pop_s) begin
        fifo_rd_nxt = ptr_inc(fifo_rd_r);
      end else begin
        fifo_rd_nxt = fifo_rd_r;
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      out_cnt_r     <= '0;
      drop_cnt_r    <= '0;
      fifo_cnt_r    <= '0;
      fifo_rd_r     <= '0;
      fifo_wr_r     <= '0;
      pcq_rd_r      <= '0;
      pcq_wr_r      <= '0;
      if_id_r       <= BUBBLE;
      if_id_valid_r <= 1'b0;
    end else begin
      fetch_pc_r    <= fetch_pc_nxt;
      out_cnt_r     <= out_cnt_nxt;
      drop_cnt_r    <= drop_cnt_nxt;
      fifo_cnt_r    <= fifo_cnt_nxt;
      fifo_rd_r     <= fifo_rd_nxt;
      fifo_wr_r     <= fifo_wr_nxt;
      pcq_rd_r      <= imem_rsp_valid ? ptr_inc(pcq_rd_r) : pcq_rd_r;
      pcq_wr_r      <= fire_s ? ptr_inc(pcq_wr_r) : pcq_wr_r;
      if_id_r       <= if_id_nxt;
      if_id_valid_r <= if_id_valid_nxt;
    end
  end

  // Storage arrays; contents are only read behind valid pointers/counts
  always_ff @(posedge clk) begin
    if (fire_s) begin
      pcq_pc_r[pcq_wr_r] <= fetch_pc_r;
    end
    if (fifo_push_s) begin
      fifo_pc_r[fifo_wr_r]   <= rsp_pc_s;
      fifo_inst_r[fifo_wr_r] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector tables driven against
// an in-order memory model with configurable latency.
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  if_id_t      if_id_reg;
  logic        if_id_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat   = 1;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  vec_t tab1 [24];
  vec_t tab2 [27];

  fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_reg(if_id_reg), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic rdy, input logic erv, input logic [31:0] ea,
                              input logic eiv, input logic [31:0] epc);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rpc; v.ready = rdy;
    v.exp_rv = erv; v.exp_addr = ea; v.exp_iv = eiv; v.exp_pc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // One clock: record acceptance, advance, then drive the due response
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
    end else if (acc) begin
      mq_addr.push_back(a);
      mq_due.push_back(cyc + lat);
    end
    cyc++;
    n_cmp++;
    if (mq_addr.size() > 2) begin
      n_bad++;
      $display("FAIL in_flight: got %0d outstanding, expected at most 2", mq_addr.size());
    end
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    stall          = v.stall;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    imem_req_ready = v.ready;
    #1;
    check_bit({tag, " req_valid"}, imem_req_valid, v.exp_rv);
    check({tag, " req_addr"}, imem_req_addr, v.exp_addr);
    check_bit({tag, " if_id_valid"}, if_id_valid, v.exp_iv);
    check({tag, " if_id_pc"}, if_id_reg.pc, v.exp_pc);
    check({tag, " if_id_inst"}, if_id_reg.fetched_inst, v.exp_iv ? mem_word(v.exp_pc) : NOP_INST);
    tick();
  endtask

  task automatic check_reset(input string tag);
    check_bit({tag, " req_valid"}, imem_req_valid, 1'b0);
    check({tag, " req_addr"}, imem_req_addr, 32'h0000_0100);
    check_bit({tag, " if_id_valid"}, if_id_valid, 1'b0);
    check({tag, " if_id_pc"}, if_id_reg.pc, 32'h0);
    check({tag, " if_id_inst"}, if_id_reg.fetched_inst, 32'h0000_0013);
  endtask

  initial begin
    // 1-cycle memory: stream, 3-cycle stall, 4-cycle ready drop, redirect+stall+response
    tab1[0]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    tab1[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0);
    tab1[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h100);
    tab1[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10C, 1'b1, 32'h104);
    tab1[4]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h110, 1'b1, 32'h108);
    tab1[5]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h114, 1'b1, 32'h108);
    tab1[6]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h114, 1'b1, 32'h108);
    tab1[7]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h114, 1'b1, 32'h108);
    tab1[8]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h114, 1'b1, 32'h10C);
    tab1[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h118, 1'b1, 32'h110);
    tab1[10] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h11C, 1'b1, 32'h114);
    tab1[11] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h120, 1'b1, 32'h118);
    tab1[12] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h120, 1'b1, 32'h11C);
    tab1[13] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h120, 1'b0, 32'h0);
    tab1[14] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h120, 1'b0, 32'h0);
    tab1[15] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h120, 1'b0, 32'h0);
    tab1[16] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h124, 1'b0, 32'h0);
    tab1[17] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h128, 1'b1, 32'h120);
    tab1[18] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h12C, 1'b1, 32'h124);
    tab1[19] = mk(1'b1, 1'b1, 32'h203, 1'b1, 1'b0, 32'h130, 1'b1, 32'h128);
    tab1[20] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    tab1[21] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h0);
    tab1[22] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h208, 1'b1, 32'h200);
    tab1[23] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h20C, 1'b1, 32'h204);
    // 3-cycle memory: PC wrap, redirect with 2 in flight, redirect+stall dropping one of two
    tab2[0]  = mk(1'b0, 1'b1, 32'hFFFF_FFFB, 1'b1, 1'b0, 32'h210, 1'b1, 32'h208);
    tab2[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    tab2[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tab2[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    tab2[4]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    tab2[5]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b1, 32'hFFFF_FFF8);
    tab2[6]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'hFFFF_FFFC);
    tab2[7]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h8,   1'b0, 32'h0);
    tab2[8]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h8,   1'b0, 32'h0);
    tab2[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h0);
    tab2[10] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h4);
    tab2[11] = mk(1'b0, 1'b1, 32'h203, 1'b1, 1'b0, 32'h10,  1'b0, 32'h0);
    tab2[12] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h200, 1'b0, 32'h0);
    tab2[13] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    tab2[14] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h0);
    tab2[15] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h208, 1'b0, 32'h0);
    tab2[16] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h208, 1'b0, 32'h0);
    tab2[17] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h208, 1'b1, 32'h200);
    tab2[18] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h20C, 1'b1, 32'h204);
    tab2[19] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h210, 1'b0, 32'h0);
    tab2[20] = mk(1'b1, 1'b1, 32'h401, 1'b1, 1'b0, 32'h210, 1'b0, 32'h0);
    tab2[21] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
    tab2[22] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h404, 1'b0, 32'h0);
    tab2[23] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h408, 1'b0, 32'h0);
    tab2[24] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h408, 1'b0, 32'h0);
    tab2[25] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h408, 1'b1, 32'h400);
    tab2[26] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h40C, 1'b1, 32'h404);

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    tick();
    tick();
    #1;
    check_reset("reset");
    reset = 1'b0;

    lat = 1;
    for (int i = 0; i < 24; i++) run_vec(tab1[i], $sformatf("p1[%0d]", i));
    lat = 3;
    for (int i = 0; i < 27; i++) run_vec(tab2[i], $sformatf("p2[%0d]", i));

    // Fill the FIFO under stall, then reset mid-operation
    stall = 1'b1; imem_req_ready = 1'b0; redirect_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    #1;
    check_reset("midreset");
    reset = 1'b0; stall = 1'b0; imem_req_ready = 1'b1;
    lat = 1;
    for (int i = 0; i < 4; i++) run_vec(tab1[i], $sformatf("post[%0d]", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
